// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every reset domain asserted, waits a release delay,
// then releases the domains one at a time (bit 0 first) with a fixed gap.
// A sequence is started by the power-on reset, a watchdog pulse or a
// software request (4-phase req/ack handshake). rst_n is active-high here.
module rst_seq_ctrl #(
    parameter int ASSERT_CYCLES = 2,
    parameter int RELEASE_DELAY = 100,
    parameter int N_DOM         = 3,
    parameter int STAGE_GAP     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    output logic             sw_rst_ack,
    input  logic             wdt_rst,
    output logic [N_DOM-1:0] dom_rst_out,
    output logic             rst_done,
    output logic [1:0]       rst_cause,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Counter must hold the longest phase length without wrapping.
    localparam int REL_SPAN = STAGE_GAP * (N_DOM - 1);
    localparam int MAX_AR   = (ASSERT_CYCLES > RELEASE_DELAY) ? ASSERT_CYCLES : RELEASE_DELAY;
    localparam int CNT_MAX  = (MAX_AR > REL_SPAN) ? MAX_AR : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ASSERT = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(RELEASE_DELAY);
    // Only used in RELEASE, which is unreachable when N_DOM == 1.
    localparam logic [CNT_W-1:0] C_GAP    = CNT_W'(STAGE_GAP);

    localparam logic [N_DOM-1:0] DOM_ALL  = {N_DOM{1'b1}};
    localparam logic [N_DOM-1:0] DOM_NONE = {N_DOM{1'b0}};
    // Only the last domain still asserted: the next release ends the sequence.
    localparam logic [N_DOM-1:0] DOM_LAST = ~(DOM_ALL >> 1'b1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_DOM-1:0]   r_dom;
    logic               r_done;
    logic               r_busy;
    logic [1:0]         r_cause;
    logic               r_ack;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N_DOM-1:0]   w_dom_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;
    logic [1:0]         w_cause_nxt;
    logic               w_ack_nxt;
    logic               w_ack_hold;
    logic               w_sw_valid;
    logic               w_restart;
    logic               w_restart_any;
    logic [1:0]         w_restart_cause;
    logic               w_enter_run;

    // Next-state, phase counting and registered-output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_dom_nxt       = r_dom;
        w_done_nxt      = r_done;
        w_busy_nxt      = r_busy;
        w_cause_nxt     = r_cause;
        w_ack_nxt       = r_ack;
        w_restart       = 1'b0;
        w_restart_cause = r_cause;
        w_enter_run     = 1'b0;

        // A request is only valid once the previous acknowledge was withdrawn.
        w_sw_valid = sw_rst_req & ~r_ack;

        // Acknowledge falls as soon as the requester drops its request.
        if (!sw_rst_req) begin
            w_ack_hold = 1'b0;
        end else begin
            w_ack_hold = r_ack;
        end
        w_ack_nxt = w_ack_hold;

        // The entry edge of a phase counts as its first cycle (counter = 1).
        case (r_state)
            ST_ASSERT: begin
                if (r_cnt == C_ASSERT) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == C_HOLD) begin
                    if (N_DOM == 1) begin
                        w_enter_run = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                        w_dom_nxt   = r_dom << 1'b1;
                        w_cnt_nxt   = C_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == C_GAP) begin
                    w_dom_nxt = r_dom << 1'b1;
                    w_cnt_nxt = C_ONE;
                    if (r_dom == DOM_LAST) begin
                        w_enter_run = 1'b1;
                    end else begin
                        w_enter_run = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = C_ZERO;
                if (w_sw_valid) begin
                    w_restart       = 1'b1;
                    w_restart_cause = CAUSE_SW;
                end else begin
                    w_restart       = 1'b0;
                end
            end
            default: begin
                // Corrupted state encoding: fall back to a full sequence.
                w_restart       = 1'b1;
                w_restart_cause = r_cause;
            end
        endcase

        // Watchdog wins over everything; a concurrent SW request stays pending.
        w_restart_any = w_restart | wdt_rst;

        if (w_restart_any) begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = C_ONE;
            w_dom_nxt   = DOM_ALL;
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
            w_cause_nxt = wdt_rst ? CAUSE_WDT : w_restart_cause;
        end else if (w_enter_run) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = C_ZERO;
            w_dom_nxt   = DOM_NONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            if (r_cause == CAUSE_SW) begin
                w_ack_nxt = 1'b1;
            end else begin
                w_ack_nxt = w_ack_hold;
            end
        end else begin
            w_done_nxt = r_done;
        end
    end

    // State and output registers; rst_n high forces the power-on state at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_ASSERT;
            r_cnt   <= C_ZERO;
            r_dom   <= DOM_ALL;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_cause <= CAUSE_POR;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dom   <= w_dom_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_cause <= w_cause_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign dom_rst_out = r_dom;
    assign rst_done    = r_done;
    assign busy        = r_busy;
    assign rst_cause   = r_cause;
    assign sw_rst_ack  = r_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl with default parameters. Stimulus pushes
// expected output snapshots keyed by absolute clock-edge number; a monitor
// samples on the falling edge and compares whenever an entry falls due.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       wdt_rst;
    logic [2:0] dom_rst_out;
    logic       rst_done;
    logic [1:0] rst_cause;
    logic       busy;

    rst_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_ack  (sw_rst_ack),
        .wdt_rst     (wdt_rst),
        .dom_rst_out (dom_rst_out),
        .rst_done    (rst_done),
        .rst_cause   (rst_cause),
        .busy        (busy)
    );

    typedef struct {
        int         at;
        logic [7:0] exp;
        string      tag;
    } sb_item_t;

    sb_item_t   sb_q[$];
    sb_item_t   mon_item;
    logic [7:0] got;
    int         edge_no  = 0;
    int         checks   = 0;
    int         failures = 0;
    int         base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic logic [7:0] pk(input logic [2:0] d, input logic dn, input logic bz,
                                      input logic [1:0] c, input logic ak);
        return {d, dn, bz, c, ak};
    endfunction

    task automatic push(input int at, input logic [2:0] d, input logic dn, input logic bz,
                        input logic [1:0] c, input logic ak, input string tag);
        sb_item_t it;
        it.at  = at;
        it.exp = pk(d, dn, bz, c, ak);
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at <= edge_no) begin
            mon_item = sb_q.pop_front();
            got = pk(dom_rst_out, rst_done, busy, rst_cause, sw_rst_ack);
            checks = checks + 1;
            if (got !== mon_item.exp) begin
                failures = failures + 1;
                $display("FAIL %s edge=%0d got dom=%b done=%b busy=%b cause=%b ack=%b exp dom=%b done=%b busy=%b cause=%b ack=%b",
                         mon_item.tag, edge_no, got[7:5], got[4], got[3], got[2:1], got[0],
                         mon_item.exp[7:5], mon_item.exp[4], mon_item.exp[3], mon_item.exp[2:1], mon_item.exp[0]);
            end
        end
    end

    // Advance to 1 ns after the given edge.
    task automatic wait_edge(input int target);
        while (edge_no < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Power-on timing with cycle 1 = first edge after release.
    task automatic push_por(input int b, input string pfx);
        push(b + 1,   3'b111, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c1"});
        push(b + 2,   3'b111, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c2"});
        push(b + 3,   3'b111, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c3"});
        push(b + 102, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c102"});
        push(b + 103, 3'b110, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c103"});
        push(b + 106, 3'b110, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c106"});
        push(b + 107, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c107"});
        push(b + 110, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, {pfx, "_c110"});
        push(b + 111, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, {pfx, "_c111"});
        push(b + 115, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, {pfx, "_c115"});
    endtask

    // Directed stimulus.
    initial begin
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        wdt_rst    = 1'b0;
        #2;
        rst_n = 1'b1;

        // Reset held across clock edges.
        wait_edge(3);
        push(edge_no, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0, "reset_state");

        // Power-on sequence.
        rst_n = 1'b0;
        base  = edge_no;
        push_por(base, "por");
        wait_edge(base + 115);
        drain();

        // Software handshake.
        sw_rst_req = 1'b1;
        base = edge_no + 1;
        push(base,       3'b111, 1'b0, 1'b1, 2'b01, 1'b0, "sw_enter");
        push(base + 101, 3'b111, 1'b0, 1'b1, 2'b01, 1'b0, "sw_hold_end");
        push(base + 102, 3'b110, 1'b0, 1'b1, 2'b01, 1'b0, "sw_bit0");
        push(base + 106, 3'b100, 1'b0, 1'b1, 2'b01, 1'b0, "sw_bit1");
        push(base + 109, 3'b100, 1'b0, 1'b1, 2'b01, 1'b0, "sw_bit2_pre");
        push(base + 110, 3'b000, 1'b1, 1'b0, 2'b01, 1'b1, "sw_done_ack");
        push(base + 120, 3'b000, 1'b1, 1'b0, 2'b01, 1'b1, "sw_no_retrigger");
        wait_edge(base + 120);
        drain();
        sw_rst_req = 1'b0;
        push(edge_no + 1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, "sw_ack_drop");
        wait_edge(edge_no + 3);
        drain();

        // Simultaneous watchdog and SW request in RUN.
        wdt_rst    = 1'b1;
        sw_rst_req = 1'b1;
        base = edge_no + 1;
        push(base,       3'b111, 1'b0, 1'b1, 2'b10, 1'b0, "both_enter");
        push(base + 110, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0, "both_run_noack");
        push(base + 111, 3'b111, 1'b0, 1'b1, 2'b01, 1'b0, "pending_sw_start");
        push(base + 221, 3'b000, 1'b1, 1'b0, 2'b01, 1'b1, "pending_sw_ack");
        wait_edge(base);
        wdt_rst = 1'b0;
        wait_edge(base + 223);
        drain();
        sw_rst_req = 1'b0;
        push(edge_no + 1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, "pending_ack_drop");
        wait_edge(edge_no + 2);
        drain();

        // Fresh power-on, watchdog pulse in HOLD, then async reset at 100.
        rst_n = 1'b1;
        push(edge_no, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0, "reassert_async");
        wait_edge(edge_no + 2);
        rst_n = 1'b0;
        base  = edge_no;
        push(base + 49,  3'b111, 1'b0, 1'b1, 2'b00, 1'b0, "wdt_pre");
        push(base + 50,  3'b111, 1'b0, 1'b1, 2'b10, 1'b0, "wdt_hit");
        push(base + 151, 3'b111, 1'b0, 1'b1, 2'b10, 1'b0, "wdt_hold_end");
        push(base + 152, 3'b110, 1'b0, 1'b1, 2'b10, 1'b0, "wdt_bit0");
        push(base + 156, 3'b100, 1'b0, 1'b1, 2'b10, 1'b0, "wdt_bit1");
        push(base + 157, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0, "async_rst_mid");
        wait_edge(base + 49);
        wdt_rst = 1'b1;
        wait_edge(base + 50);
        wdt_rst = 1'b0;
        wait_edge(base + 157);
        rst_n = 1'b1;
        wait_edge(base + 160);
        drain();
        rst_n = 1'b0;
        base  = edge_no;
        push_por(base, "por2");
        wait_edge(base + 115);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL global_timeout time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter ASSERT_CYCLES, default 2: number of cycles all domain resets are held asserted at sequence start (>=1).
REQ-002 SHALL have parameter RELEASE_DELAY, default 100: number of hold cycles between the ASSERT phase and the first domain release (>=1).
REQ-003 SHALL have parameter N_DOM, default 3: number of reset domains (1..8).
REQ-004 SHALL have parameter STAGE_GAP, default 4: number of cycles between successive domain releases (>=1).
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port sw_rst_req, input, 1 bit: software reset request, level, 4-phase handshake.
REQ-008 SHALL have port sw_rst_ack, output, 1 bit: software reset completion acknowledge.
REQ-009 SHALL have port wdt_rst, input, 1 bit: watchdog reset, sampled every cycle, one-cycle pulse sufficient.
REQ-010 SHALL have port dom_rst_out, output, N_DOM bits: per-domain reset, active-high, bit 0 released first.
REQ-011 SHALL have port rst_done, output, 1 bit: high when all domains are released.
REQ-012 SHALL have port rst_cause, output, 2 bits: cause of last sequence (00 POR, 01 SW, 10 WDT).
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than RUN.

Function
REQ-014 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN; all outputs registered.
REQ-015 ASSERT SHALL last exactly ASSERT_CYCLES cycles, then go to HOLD; all dom_rst_out bits = 1.
REQ-016 HOLD SHALL last exactly RELEASE_DELAY cycles, then go to RELEASE; all dom_rst_out bits = 1.
REQ-017 On the edge entering RELEASE SHALL clear dom_rst_out[0]; each bit i SHALL clear exactly STAGE_GAP*i cycles after bit 0; cleared bits stay cleared.
REQ-018 On the edge clearing bit N_DOM-1, SHALL enter RUN and set rst_done=1 and busy=0 on that same edge; with N_DOM=1 this is the edge entering RELEASE.
REQ-019 In RUN, wdt_rst=1 SHALL cause: next edge -> ASSERT, dom_rst_out all 1, rst_done=0, busy=1, rst_cause=10.
REQ-020 In RUN, sw_rst_req=1 with sw_rst_ack=0 SHALL cause: next edge -> ASSERT, all domains asserted, rst_done=0, busy=1, rst_cause=01.
REQ-021 wdt_rst and a valid SW request in the same cycle -> WDT wins (rst_cause=10); the SW request stays pending and is not acknowledged.
REQ-022 wdt_rst in ASSERT/HOLD/RELEASE SHALL restart from ASSERT on the next edge: counters cleared, all domains re-asserted, rst_cause=10.
REQ-023 sw_rst_req outside RUN SHALL be ignored until RUN is reached; it is then evaluated per REQ-020.
REQ-024 sw_rst_ack SHALL rise on the edge entering RUN at the end of a sequence with rst_cause=01, and fall on the first edge where sw_rst_req=0.
REQ-025 While sw_rst_ack=1, sw_rst_req=1 SHALL NOT start a new sequence; requester must drop req and see ack=0 before re-requesting.
REQ-026 Phase counter width SHALL be clog2(max(ASSERT_CYCLES, RELEASE_DELAY, STAGE_GAP*(N_DOM-1))+1); no wrap before terminal count.

Reset
REQ-027 rst_n=1 SHALL immediately (asynchronously) force: state=ASSERT, counters=0, dom_rst_out all 1, rst_done=0, busy=1, sw_rst_ack=0, rst_cause=00.
REQ-028 rst_n assertion mid-sequence or in RUN SHALL abort all activity and discard any pending SW or WDT request.
REQ-029 The first rising clk edge with rst_n=0 SHALL count as ASSERT cycle 1.

Verification (defaults: ASSERT_CYCLES=2, RELEASE_DELAY=100, N_DOM=3, STAGE_GAP=4; cycle 1 = first edge after rst_n deasserts)
REQ-030 POR: release rst_n, no other stimulus -> dom_rst_out=111 through edge 102; 110 at edge 103; 100 at 107; 000 with rst_done=1, busy=0 at 111; rst_cause=00.
REQ-031 SW handshake: in RUN raise req -> next edge dom_rst_out=111, cause=01; sequence completes 110 cycles later with ack=1; drop req -> ack=0 next edge; holding req high with ack=1 triggers no new sequence.
REQ-032 WDT mid-HOLD: wdt_rst pulse at edge 50 -> dom_rst_out stays 111, counters restart, bit0 clears 102 edges later, rst_cause=10.
REQ-033 Simultaneous: wdt_rst and sw_rst_req both 1 in RUN -> cause=10, ack stays 0; after RUN a second sequence starts with cause=01 and ends with ack=1.
REQ-034 rst_n pulse while dom_rst_out=100 -> asynchronously 111, rst_done=0, cause=00, ack=0; full POR timing of REQ-030 repeats.
